// File: rtl/card_shoe.sv
// card_shoe: 52-card dealer without replacement answering single-card requests from the game FSM.
// A request picks a pseudo-random start slot and scans forward, one slot per clock, to the first undealt card.
module card_shoe #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned LOW_WATER = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [3:0] card_val,
    output logic [5:0] card_idx,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       shoe_low,
    output logic       reshuffled
);

    localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK   = 16'hB400;
    localparam logic [5:0]  DECK_SIZE   = 6'd52;
    localparam logic [5:0]  LAST_IDX    = 6'd51;
    localparam logic [5:0]  LOW_WATER_C = 6'(LOW_WATER);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [51:0] used_r, used_s;
    logic [5:0]  cards_left_r, cards_left_s;
    logic [5:0]  ptr_r, ptr_s;
    logic        card_valid_r, card_valid_s;
    logic [3:0]  card_val_r, card_val_s;
    logic [5:0]  card_idx_r, card_idx_s;
    logic        shoe_low_r, shoe_low_s;
    logic        reshuffled_r, reshuffled_s;
    logic [15:0] lfsr_r;
    logic [5:0]  start_s;

    // Galois right-shift step; the feedback taps are applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Fold a 6-bit random value into the deck range 0..51.
    function automatic logic [5:0] fold_start(input logic [5:0] s);
        logic [5:0] f;
        if (s >= DECK_SIZE) begin
            f = s - DECK_SIZE;
        end else begin
            f = s;
        end
        return f;
    endfunction

    // Rank within a suit: ace counts 1, ten and face cards count 10.
    function automatic logic [3:0] card_map(input logic [5:0] idx);
        logic [5:0] r;
        logic [3:0] v;
        r = idx % 6'd13;
        if (r == 6'd0) begin
            v = 4'd1;
        end else if (r >= 6'd9) begin
            v = 4'd10;
        end else begin
            v = r[3:0] + 4'd1;
        end
        return v;
    endfunction

    assign start_s = fold_start(lfsr_r[5:0]);

    // Next-state and datapath decisions for the IDLE/SEARCH controller.
    always_comb begin
        state_s      = state_r;
        used_s       = used_r;
        cards_left_s = cards_left_r;
        ptr_s        = ptr_r;
        card_valid_s = 1'b0;
        card_val_s   = card_val_r;
        card_idx_s   = card_idx_r;
        reshuffled_s = 1'b0;
        case (state_r)
            IDLE: begin
                // An empty shoe is refilled on demand so the following search always finds a card.
                if (shuffle || (req && (cards_left_r == 6'd0))) begin
                    used_s       = 52'd0;
                    cards_left_s = DECK_SIZE;
                    reshuffled_s = 1'b1;
                end else begin
                    used_s       = used_r;
                    cards_left_s = cards_left_r;
                end
                if (req) begin
                    ptr_s   = start_s;
                    state_s = SEARCH;
                end else begin
                    ptr_s   = ptr_r;
                    state_s = IDLE;
                end
            end
            SEARCH: begin
                if (!used_r[ptr_r]) begin
                    used_s[ptr_r] = 1'b1;
                    cards_left_s  = cards_left_r - 6'd1;
                    card_idx_s    = ptr_r;
                    card_val_s    = card_map(ptr_r);
                    card_valid_s  = 1'b1;
                    state_s       = IDLE;
                end else begin
                    ptr_s   = (ptr_r == LAST_IDX) ? 6'd0 : (ptr_r + 6'd1);
                    state_s = SEARCH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        shoe_low_s = (cards_left_s < LOW_WATER_C);
    end

    // State, deck bookkeeping, output and LFSR registers; the LFSR keeps stepping while busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            used_r       <= 52'd0;
            cards_left_r <= DECK_SIZE;
            ptr_r        <= 6'd0;
            card_valid_r <= 1'b0;
            card_val_r   <= 4'd0;
            card_idx_r   <= 6'd0;
            shoe_low_r   <= 1'b0;
            reshuffled_r <= 1'b0;
            lfsr_r       <= SEED_EFF;
        end else begin
            state_r      <= state_s;
            used_r       <= used_s;
            cards_left_r <= cards_left_s;
            ptr_r        <= ptr_s;
            card_valid_r <= card_valid_s;
            card_val_r   <= card_val_s;
            card_idx_r   <= card_idx_s;
            shoe_low_r   <= shoe_low_s;
            reshuffled_r <= reshuffled_s;
            lfsr_r       <= lfsr_step(lfsr_r);
        end
    end

    assign card_valid = card_valid_r;
    assign card_val   = card_val_r;
    assign card_idx   = card_idx_r;
    assign busy       = (state_r == SEARCH);
    assign cards_left = cards_left_r;
    assign shoe_low   = shoe_low_r;
    assign reshuffled = reshuffled_r;

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: a transaction-level shoe model predicts every output each cycle,
// and directed deal sequences pin deck coverage, refill, contention and reset behaviour.
`timescale 1ns/1ps
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       shuffle = 1'b0;
    logic       card_valid;
    logic [3:0] card_val;
    logic [5:0] card_idx;
    logic       busy;
    logic [5:0] cards_left;
    logic       shoe_low;
    logic       reshuffled;

    int checks = 0;
    int failures = 0;

    card_shoe #(.LFSR_SEED(16'hACE1), .LOW_WATER(15)) dut (
        .clk(clk), .rst(rst), .req(req), .shuffle(shuffle),
        .card_valid(card_valid), .card_val(card_val), .card_idx(card_idx),
        .busy(busy), .cards_left(cards_left), .shoe_low(shoe_low), .reshuffled(reshuffled)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int value_of(input int idx);
        int rank;
        rank = idx % 13;
        if (rank == 0) return 1;
        if (rank >= 9) return 10;
        return rank + 1;
    endfunction

    // Shoe model: a request resolves at once to the first free slot from the random start;
    // the card shows up after as many clocks as slots probed.
    int m_lfsr;
    bit m_used[52];
    int m_left, m_wait, m_pidx, m_val, m_idx;
    bit m_valid, m_resh, m_low;
    bit cmp_en = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b0;
        m_resh  = 1'b0;
        if (!rst) begin
            m_lfsr = 'hACE1;
            foreach (m_used[i]) m_used[i] = 1'b0;
            m_left = 52; m_wait = 0; m_pidx = 0; m_val = 0; m_idx = 0;
        end else begin
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_used[m_pidx] = 1'b1;
                    m_left--;
                    m_idx = m_pidx;
                    m_val = value_of(m_pidx);
                    m_valid = 1'b1;
                end
            end else begin
                if (shuffle || (req && m_left == 0)) begin
                    foreach (m_used[i]) m_used[i] = 1'b0;
                    m_left = 52;
                    m_resh = 1'b1;
                end
                if (req) begin
                    int s;
                    s = m_lfsr % 64;
                    if (s >= 52) s -= 52;
                    for (int k = 0; k < 52; k++) begin
                        if (!m_used[(s + k) % 52]) begin
                            m_pidx = (s + k) % 52;
                            m_wait = k + 1;
                            break;
                        end
                    end
                end
            end
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
        end
        m_low = (m_left < 15);
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_card_valid", int'(card_valid), int'(m_valid));
            check("cmp_reshuffled", int'(reshuffled), int'(m_resh));
            check("cmp_busy", int'(busy), int'(m_wait > 0));
            check("cmp_cards_left", int'(cards_left), m_left);
            check("cmp_shoe_low", int'(shoe_low), int'(m_low));
            check("cmp_card_val", int'(card_val), m_val);
            check("cmp_card_idx", int'(card_idx), m_idx);
        end
    end

    // One request (optionally with shuffle), waiting a bounded time for the card.
    task automatic deal(input bit with_shuffle, output int idx, output int val,
                        output int lat, output bit resh);
        bit got;
        got = 1'b0; resh = 1'b0; lat = 0; idx = -1; val = -1;
        req = 1'b1;
        shuffle = with_shuffle;
        @(negedge clk);
        req = 1'b0;
        shuffle = 1'b0;
        lat = 1;
        if (reshuffled === 1'b1) resh = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (reshuffled === 1'b1) resh = 1'b1;
            if (card_valid === 1'b1) begin
                got = 1'b1;
                idx = int'(card_idx);
                val = int'(card_val);
            end
        end
        check("deal_done", int'(got), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, val, lat, nvalid, distinct;
        bit resh;
        bit seen[52];
        int hist[11];

        // T1 reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("t1_cards_left", int'(cards_left), 52);
        check("t1_busy", int'(busy), 0);
        check("t1_card_valid", int'(card_valid), 0);
        check("t1_reshuffled", int'(reshuffled), 0);
        rst = 1'b1;

        // T2 single deal on the first edge after reset: seed ACE1 gives start 33 (value 8), one probe
        deal(1'b0, idx, val, lat, resh);
        check("t2_idx", idx, 33);
        check("t2_val", val, 8);
        check("t2_map", val, value_of(idx));
        check("t2_latency", lat, 2);
        check("t2_cards_left", int'(cards_left), 51);
        check("t2_busy", int'(busy), 0);
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (hist[i]) hist[i] = 0;
        if (idx >= 0 && idx < 52) seen[idx] = 1'b1;
        if (val >= 1 && val <= 10) hist[val]++;

        // T3 rest of the deck
        for (int i = 2; i <= 52; i++) begin
            deal(1'b0, idx, val, lat, resh);
            if (idx >= 0 && idx < 52) seen[idx] = 1'b1;
            if (val >= 1 && val <= 10) hist[val]++;
            check("t3_cards_left", int'(cards_left), 52 - i);
            check("t3_shoe_low", int'(shoe_low), int'((52 - i) < 15));
        end
        distinct = 0;
        foreach (seen[i]) if (seen[i]) distinct++;
        check("t3_distinct", distinct, 52);
        check("t3_hist_10", hist[10], 16);
        for (int v = 1; v <= 9; v++) check("t3_hist_low", hist[v], 4);
        check("t3_empty", int'(cards_left), 0);

        // T4 automatic refill on the 53rd request
        deal(1'b0, idx, val, lat, resh);
        check("t4_reshuffled", int'(resh), 1);
        check("t4_cards_left", int'(cards_left), 51);
        check("t4_shoe_low", int'(shoe_low), 0);
        check("t4_map", val, value_of(idx));

        // T5 request while busy is dropped
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("t5_busy", int'(busy), 1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        nvalid = (card_valid === 1'b1) ? 1 : 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (card_valid === 1'b1) nvalid++;
        end
        check("t5_one_card", nvalid, 1);
        check("t5_cards_left", int'(cards_left), 50);

        // T5 shuffle and request together after 10 more deals
        for (int i = 0; i < 10; i++) deal(1'b0, idx, val, lat, resh);
        check("t5_before_shuffle", int'(cards_left), 40);
        deal(1'b1, idx, val, lat, resh);
        check("t5_shuffle_resh", int'(resh), 1);
        check("t5_shuffle_left", int'(cards_left), 51);

        // Shuffle alone refills without dealing
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        check("shuffle_only_resh", int'(reshuffled), 1);
        check("shuffle_only_left", int'(cards_left), 52);
        @(negedge clk);

        // T6 reset one cycle after a request aborts the search
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("t6_no_card", int'(card_valid), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_cards_left", int'(cards_left), 52);
        rst = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (card_valid === 1'b1) nvalid++;
        end
        check("t6_quiet", nvalid, 0);
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < 52; i++) begin
            deal(1'b0, idx, val, lat, resh);
            if (idx >= 0 && idx < 52) seen[idx] = 1'b1;
        end
        distinct = 0;
        foreach (seen[i]) if (seen[i]) distinct++;
        check("t6_distinct", distinct, 52);
        check("t6_empty", int'(cards_left), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
